// File: rtl/program_loader.sv
// Boot-time program loader: receives a framed byte stream, writes it into program
// memory, verifies an XOR checksum, then releases the core and tracks its run time.
module program_loader #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    input  logic              cpu_halt,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data,
    output logic              mem_wr,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic              halted,
    output logic [CWIDTH-1:0] run_cycles,
    output logic [2:0]        dbg_state
);

    localparam int          CNT_W = AWIDTH + 1;
    localparam int unsigned CAP   = 2 ** AWIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN    = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        RUN    = 3'd4,
        HALTED = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  addr_cnt;
    logic [CNT_W-1:0]  addr_nxt;
    logic [CNT_W-1:0]  target;
    logic [CNT_W-1:0]  len_words;
    logic [DWIDTH-1:0] csum;
    logic [AWIDTH-1:0] mem_addr_q;
    logic [DWIDTH-1:0] mem_data_q;
    logic              mem_wr_q;
    logic [CWIDTH-1:0] run_q;
    logic              xfer;
    logic              len_bad;
    logic              last_word;
    logic              load_start;

    // Stream handshake: a byte moves only in a cycle where in_valid and in_ready
    // are both high; in_data is don't-care otherwise and in_valid may be held.
    assign xfer      = in_valid && in_ready;
    assign len_bad   = 32'(in_data) > CAP;
    assign len_words = (in_data == '0) ? CNT_W'(CAP) : CNT_W'(in_data);
    assign addr_nxt  = addr_cnt + CNT_W'(1);
    assign last_word = (addr_nxt == target);
    assign load_start = start && (state == IDLE || state == RUN ||
                                  state == HALTED || state == ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (start) state_n = LEN;
            LEN:    if (xfer) state_n = len_bad ? ERR : DATA;
            DATA:   if (xfer && last_word) state_n = CSUM;
            CSUM:   if (xfer) state_n = (in_data == csum) ? RUN : ERR;
            // A start in the same cycle as halt takes priority.
            RUN: begin
                if (start) begin
                    state_n = LEN;
                end else if (cpu_halt) begin
                    state_n = HALTED;
                end
            end
            HALTED: if (start) state_n = LEN;
            ERR:    if (start) state_n = LEN;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        halted   = 1'b0;
        case (state)
            LEN, DATA, CSUM: in_ready = 1'b1;
            RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            HALTED: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
                halted  = 1'b1;
            end
            ERR: err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_cnt   <= '0;
            target     <= '0;
            csum       <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wr_q   <= 1'b0;
            run_q      <= '0;
        end else begin
            mem_wr_q <= 1'b0;
            if (load_start) begin
                addr_cnt <= '0;
                csum     <= '0;
                run_q    <= '0;
            end
            if (state == LEN && xfer && !len_bad) begin
                target <= len_words;
            end
            if (state == DATA && xfer) begin
                mem_addr_q <= addr_cnt[AWIDTH-1:0];
                mem_data_q <= in_data;
                mem_wr_q   <= 1'b1;
                csum       <= csum ^ in_data;
                addr_cnt   <= addr_nxt;
            end
            // The halt cycle itself is not counted: the core has stopped.
            if (state == RUN && !start && !cpu_halt && run_q != '1) begin
                run_q <= run_q + CWIDTH'(1);
            end
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_wr     = mem_wr_q;
    assign run_cycles = run_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames are driven byte by byte and every
// memory write is checked against an expected (addr,data) queue.
module tb_program_loader;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          cpu_halt;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wr;
    logic          cpu_rst;
    logic          done;
    logic          err;
    logic          halted;
    logic [CW-1:0] run_cycles;
    logic [2:0]    dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [AW+DW-1:0] exp_q[$];

    program_loader #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .cpu_halt(cpu_halt),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
        .cpu_rst(cpu_rst), .done(done), .err(err), .halted(halted),
        .run_cycles(run_cycles), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard: every write must match the head of the expected queue
    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", mem_addr, mem_data);
            end else begin
                logic [AW+DW-1:0] want;
                want = exp_q.pop_front();
                if ({mem_addr, mem_data} !== want) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%h want addr=%0d data=%h",
                             mem_addr, mem_data, want[AW+DW-1:DW], want[DW-1:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic push_exp(input int a, input logic [DW-1:0] d);
        exp_q.push_back({AW'(a), d});
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [DW-1:0] b);
        int k;
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: byte %h got in_ready=%b want 1", b, in_ready);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_byte_gappy(input logic [DW-1:0] b);
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            @(negedge clk);
        end
        send_byte(b);
    endtask

    // tests
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (mem_wr !== 1'b0)     begin n_fail++; $display("FAIL rst_mem_wr: got %b want 0", mem_wr); end
        n_cmp++; if (cpu_rst !== 1'b1)    begin n_fail++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
        n_cmp++; if ({done, err, halted} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {done, err, halted}); end
        n_cmp++; if (mem_addr !== '0)     begin n_fail++; $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); end
        n_cmp++; if (mem_data !== '0)     begin n_fail++; $display("FAIL rst_mem_data: got %h want 0", mem_data); end
        n_cmp++; if (run_cycles !== '0)   begin n_fail++; $display("FAIL rst_run_cycles: got %0d want 0", run_cycles); end
        n_cmp++; if (dbg_state !== 3'd0)  begin n_fail++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        do_start();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", in_ready); end
        push_exp(0, 8'h0A); push_exp(1, 8'h55); push_exp(2, 8'hE0);
        send_byte(8'h03);
        send_byte(8'h0A);
        send_byte(8'h55);
        send_byte(8'hE0);
        n_cmp++; if (cpu_rst !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL basic_pre_csum: got cpu_rst=%b done=%b want 1/0", cpu_rst, done); end
        send_byte(8'hBF);
        in_valid = 1'b0;
        n_cmp++; if (done !== 1'b1)    begin n_fail++; $display("FAIL basic_done: got %b want 1", done); end
        n_cmp++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_rst: got %b want 0", cpu_rst); end
        n_cmp++; if (mem_wr !== 1'b0)  begin n_fail++; $display("FAIL basic_wr_pulse: got %b want 0", mem_wr); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_writes: got %0d missing want 0", exp_q.size()); end
    endtask

    task automatic test_bad_checksum();
        do_start();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL badcs_start_done: got %b want 0", done); end
        push_exp(0, 8'h0A); push_exp(1, 8'h55); push_exp(2, 8'hE0);
        send_byte(8'h03); send_byte(8'h0A); send_byte(8'h55); send_byte(8'hE0);
        send_byte(8'hBE);
        in_valid = 1'b0;
        n_cmp++; if (err !== 1'b1)      begin n_fail++; $display("FAIL badcs_err: got %b want 1", err); end
        n_cmp++; if (cpu_rst !== 1'b1)  begin n_fail++; $display("FAIL badcs_cpu_rst: got %b want 1", cpu_rst); end
        n_cmp++; if (done !== 1'b0)     begin n_fail++; $display("FAIL badcs_done: got %b want 0", done); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL badcs_ready: got %b want 0", in_ready); end
        do_start();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL badcs_err_clear: got %b want 0", err); end
        push_exp(0, 8'h0A); push_exp(1, 8'h55); push_exp(2, 8'hE0);
        send_byte(8'h03); send_byte(8'h0A); send_byte(8'h55); send_byte(8'hE0);
        send_byte(8'hBF);
        in_valid = 1'b0;
        n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL badcs_reload: got done=%b err=%b want 1/0", done, err); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL badcs_writes: got %0d missing want 0", exp_q.size()); end
    endtask

    task automatic test_full_length();
        do_start();
        send_byte(8'h00);
        for (int i = 0; i < 32; i++) begin
            push_exp(i, DW'(i));
            send_byte(DW'(i));
        end
        send_byte(8'h00);
        in_valid = 1'b0;
        n_cmp++; if (done !== 1'b1)     begin n_fail++; $display("FAIL full_done: got %b want 1", done); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_writes: got %0d missing want 0", exp_q.size()); end
        n_cmp++; if (mem_addr !== 5'd31) begin n_fail++; $display("FAIL full_last_addr: got %0d want 31", mem_addr); end
    endtask

    task automatic test_bad_length();
        do_start();
        send_byte(8'h21);
        in_valid = 1'b0;
        n_cmp++; if (err !== 1'b1)      begin n_fail++; $display("FAIL badlen_err: got %b want 1", err); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL badlen_ready: got %b want 0", in_ready); end
        n_cmp++; if (mem_wr !== 1'b0)   begin n_fail++; $display("FAIL badlen_no_write: got %b want 0", mem_wr); end
        repeat (2) @(negedge clk);
        n_cmp++; if (dbg_state !== 3'd6) begin n_fail++; $display("FAIL badlen_state: got %0d want 6", dbg_state); end
    endtask

    task automatic test_random_valid();
        do_start();
        push_exp(0, 8'h11); push_exp(1, 8'h22); push_exp(2, 8'h33);
        push_exp(3, 8'h44); push_exp(4, 8'h55);
        send_byte_gappy(8'h05);
        send_byte_gappy(8'h11);
        send_byte_gappy(8'h22);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (dbg_state !== 3'd2 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rand_start_ignored: got state=%0d ready=%b want 2/1", dbg_state, in_ready); end
        send_byte_gappy(8'h33);
        send_byte_gappy(8'h44);
        send_byte_gappy(8'h55);
        send_byte_gappy(8'h11);
        in_valid = 1'b0;
        n_cmp++; if (done !== 1'b1)     begin n_fail++; $display("FAIL rand_done: got %b want 1", done); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_writes: got %0d missing want 0", exp_q.size()); end
    endtask

    task automatic test_run_halt();
        do_start();
        push_exp(0, 8'h3C); push_exp(1, 8'h0F);
        send_byte(8'h02); send_byte(8'h3C); send_byte(8'h0F);
        cpu_halt = 1'b0;
        send_byte(8'h33);
        in_valid = 1'b0;
        n_cmp++; if (run_cycles !== 16'd0) begin n_fail++; $display("FAIL run_start_count: got %0d want 0", run_cycles); end
        repeat (10) @(negedge clk);
        n_cmp++; if (run_cycles !== 16'd10) begin n_fail++; $display("FAIL run_count10: got %0d want 10", run_cycles); end
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        n_cmp++; if (halted !== 1'b1)       begin n_fail++; $display("FAIL halt_flag: got %b want 1", halted); end
        n_cmp++; if (run_cycles !== 16'd10) begin n_fail++; $display("FAIL halt_count: got %0d want 10", run_cycles); end
        repeat (3) @(negedge clk);
        n_cmp++; if (run_cycles !== 16'd10 || done !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got count=%0d done=%b want 10/1", run_cycles, done); end
        do_start();
        n_cmp++; if (cpu_rst !== 1'b1)   begin n_fail++; $display("FAIL restart_cpu_rst: got %b want 1", cpu_rst); end
        n_cmp++; if (run_cycles !== '0)  begin n_fail++; $display("FAIL restart_count: got %0d want 0", run_cycles); end
        n_cmp++; if ({done, halted} !== 2'b00) begin n_fail++; $display("FAIL restart_flags: got %b want 00", {done, halted}); end
    endtask

    task automatic test_start_wins();
        push_exp(0, 8'h7E);
        send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7E);
        in_valid = 1'b0;
        n_cmp++; if (dbg_state !== 3'd4) begin n_fail++; $display("FAIL sw_run: got state=%0d want 4", dbg_state); end
        start = 1'b1;
        cpu_halt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cpu_halt = 1'b0;
        n_cmp++; if (dbg_state !== 3'd1 || halted !== 1'b0) begin n_fail++; $display("FAIL start_wins: got state=%0d halted=%b want 1/0", dbg_state, halted); end
        n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL sw_cpu_rst: got %b want 1", cpu_rst); end
    endtask

    task automatic test_async_reset();
        do_start();
        push_exp(0, 8'h0A); push_exp(1, 8'h55);
        send_byte(8'h03); send_byte(8'h0A); send_byte(8'h55);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (mem_wr !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_wr_ready: got wr=%b ready=%b want 0/0", mem_wr, in_ready); end
        n_cmp++; if (mem_addr !== '0 || mem_data !== '0) begin n_fail++; $display("FAIL arst_mem: got addr=%0d data=%h want 0/00", mem_addr, mem_data); end
        n_cmp++; if (cpu_rst !== 1'b1 || dbg_state !== 3'd0) begin n_fail++; $display("FAIL arst_state: got cpu_rst=%b state=%0d want 1/0", cpu_rst, dbg_state); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL arst_writes: got %0d missing want 0", exp_q.size()); end
        @(negedge clk);
        rst = 1'b1;
        do_start();
        push_exp(0, 8'h0A); push_exp(1, 8'h55); push_exp(2, 8'hE0);
        send_byte(8'h03); send_byte(8'h0A); send_byte(8'h55); send_byte(8'hE0);
        send_byte(8'hBF);
        in_valid = 1'b0;
        n_cmp++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin n_fail++; $display("FAIL arst_reload: got done=%b cpu_rst=%b want 1/0", done, cpu_rst); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL arst_reload_writes: got %0d missing want 0", exp_q.size()); end
    endtask

    initial begin
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        cpu_halt = 1'b0;
        rst      = 1'b1;
        test_reset();
        test_basic_load();
        test_bad_checksum();
        test_full_length();
        test_bad_length();
        test_random_valid();
        test_run_halt();
        test_start_wins();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
